vga_test_pattern_gen: RTL and testbench
=======================================

VGA_TEST_PATTERN_GEN -- requirements
Module: vga_test_pattern_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning): VIDEO_WIDTH, 3, bits per colour channel (1..8); TOTAL_COLS, 800, clocks per line; TOTAL_ROWS, 525, lines per frame; ACTIVE_COLS, 640, visible columns; ACTIVE_ROWS, 480, visible rows.
REQ-002 SHALL have ports: i_Clk  in  1  pixel clock; the only clock.
REQ-003 SHALL have port: i_Rst_L  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: i_HSync  in  1  raw HSync, high during active columns; i_VSync  in  1  raw VSync, high during active rows.
REQ-005 SHALL have port: i_Pattern  in  4  requested pattern ID.
REQ-006 SHALL have ports: o_HSync  out  1; o_VSync  out  1  (syncs delayed to align with video).
REQ-007 SHALL have ports: o_Red_Video, o_Grn_Video, o_Blu_Video  out  VIDEO_WIDTH  pattern pixel data.
REQ-008 SHALL have port: o_Frame_Start  out  1  one-cycle pulse marking pixel (0,0).

Function
REQ-009 SHALL register i_HSync/i_VSync into stage-1 registers r_HSync/r_VSync every cycle.
REQ-010 SHALL detect frame start when i_VSync=1 and r_VSync=0. In that cycle, col and row counters load 0.
REQ-011 When no frame start is detected, col SHALL increment and wrap from TOTAL_COLS-1 to 0. Row SHALL increment on each col wrap and wrap from TOTAL_ROWS-1 to 0.
REQ-012 Counter widths SHALL be ceil(log2(TOTAL_COLS)) and ceil(log2(TOTAL_ROWS)).
REQ-013 A frame-start edge arriving mid-line or mid-frame SHALL force counters to 0 (resync); it has priority over wrap.
REQ-014 SHALL latch i_Pattern into r_Pattern only on the frame-start cycle. Changes at any other time SHALL be ignored until the next frame start.
REQ-015 SHALL keep an 8-bit frame counter that increments on each frame start and wraps 255->0.
REQ-016 Stage 2 SHALL update o_HSync<=r_HSync and o_VSync<=r_VSync, and compute video from stage-1 col/row/r_Pattern. Latency from input syncs to all outputs SHALL be exactly 2 cycles.
REQ-017 When col>=ACTIVE_COLS or row>=ACTIVE_ROWS, all video outputs SHALL be 0 regardless of pattern.
REQ-018 In the active area, colour "white" means all bits 1 and "black" means all bits 0; patterns SHALL be:
 - 0: black.
 - 1: solid red.
 - 2: solid green.
 - 3: solid blue.
 - 4: checkerboard; white when col[5] XOR row[5]=1, else black.
 - 5: 8 colour bars.
 - 6: border; white when col=0, col=ACTIVE_COLS-1, row=0 or row=ACTIVE_ROWS-1, else black.
 - 7: all channels = frame counter bits [7:8-VIDEO_WIDTH].
 - 8-15: black.
REQ-019 Colour bars SHALL use bar index k = col/(ACTIVE_COLS/8), saturated at 7. Red SHALL be all-ones iff k[0]; Grn iff k[1]; Blu iff k[2].
REQ-020 o_Frame_Start SHALL assert for exactly one cycle, 2 cycles after the input VSync rising edge, coincident with the output pixel (0,0).
REQ-021 No handshake or back-pressure SHALL exist; the block is free-running, one pixel per clock.

Reset
REQ-022 While i_Rst_L=0 at a rising i_Clk edge, the following SHALL go to 0: r_HSync, r_VSync, counters, r_Pattern, frame counter, o_HSync, o_VSync, all video outputs, o_Frame_Start.
REQ-023 After reset release, if i_VSync=1 on the first cycle, a frame start SHALL be detected immediately (r_VSync=0). Counters SHALL otherwise free-run from 0 until the next edge.
REQ-024 Reset asserted mid-frame SHALL take effect at the next clock edge with no partial-pixel output.

Verification
REQ-025 Default parameters, sync generator running, i_Pattern=5: output line 10 SHALL show cols 0-79 = 0/0/0 and cols 80-159 R=7,G=0,B=0; cols 560-639 SHALL be 7/7/7 and cols 640-799 SHALL be 0.
REQ-026 Input VSync rising edge at clock T: o_Frame_Start=1 only at T+2. o_HSync/o_VSync SHALL equal inputs delayed 2 cycles throughout.
REQ-027 i_Pattern changed 1->3 mid-frame: remainder of the frame SHALL stay red (R=7,G=0,B=0); the next frame SHALL be blue (0/0/7).
REQ-028 i_Pattern=7 over 257 frames: frame 1 SHALL show value 0 (counter=1, bits[7:5]=0); frame 32 SHALL show 1. The counter SHALL wrap at 256 frames.
REQ-029 VSync edge injected at col 300 row 100: the next output pixel after 2 cycles SHALL be (0,0) data with o_Frame_Start=1.
REQ-030 i_Rst_L=0 for 3 cycles mid-active-region: all outputs SHALL be 0 the cycle after the first low edge. After release, i_VSync=1 SHALL cause o_Frame_Start 2 cycles later.

Source files
------------

// File: rtl/vga_test_pattern_gen_if.sv
// vga_test_pattern_gen_if
// Groups the raw sync / pattern-select inputs and the aligned video outputs
// of the test pattern generator into one bundle.
//   i_HSync, i_VSync   raw syncs from the sync generator (high while active)
//   i_Pattern          requested pattern ID, sampled at frame start
//   o_HSync, o_VSync   syncs delayed to line up with the video
//   o_Red/Grn/Blu_Video pattern pixel data, VIDEO_WIDTH bits per channel
//   o_Frame_Start      one-cycle pulse coincident with output pixel (0,0)
// Modports: master = the pattern generator, slave = the video consumer.
interface vga_test_pattern_gen_if #(
  parameter int VIDEO_WIDTH = 3
);
  logic                   i_HSync;
  logic                   i_VSync;
  logic [3:0]             i_Pattern;
  logic                   o_HSync;
  logic                   o_VSync;
  logic [VIDEO_WIDTH-1:0] o_Red_Video;
  logic [VIDEO_WIDTH-1:0] o_Grn_Video;
  logic [VIDEO_WIDTH-1:0] o_Blu_Video;
  logic                   o_Frame_Start;

  modport master (
    input  i_HSync, i_VSync, i_Pattern,
    output o_HSync, o_VSync, o_Red_Video, o_Grn_Video, o_Blu_Video, o_Frame_Start
  );

  modport slave (
    output i_HSync, i_VSync, i_Pattern,
    input  o_HSync, o_VSync, o_Red_Video, o_Grn_Video, o_Blu_Video, o_Frame_Start
  );
endinterface

// File: rtl/vga_test_pattern_gen.sv
// vga_test_pattern_gen
// Free-running VGA test pattern generator, one pixel per clock.
// Stage 1 registers the raw syncs, tracks column/row from the VSync rising
// edge, latches the pattern ID and counts frames. Stage 2 produces the pixel
// colour and the delayed syncs, so every output lags the input syncs by
// exactly two clocks.
// Ports:
//   i_Clk    pixel clock (only clock)
//   i_Rst_L  synchronous active-low reset
//   vid      vga_test_pattern_gen_if.master: raw syncs and pattern ID in,
//            aligned syncs, RGB video and frame-start pulse out
module vga_test_pattern_gen #(
  parameter int VIDEO_WIDTH = 3,
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480
) (
  input logic                   i_Clk,
  input logic                   i_Rst_L,
  vga_test_pattern_gen_if.master vid
);

  localparam int COL_W = (TOTAL_COLS > 1) ? $clog2(TOTAL_COLS) : 1;
  localparam int ROW_W = (TOTAL_ROWS > 1) ? $clog2(TOTAL_ROWS) : 1;
  // Bar width; clamped so tiny active widths never divide by zero.
  localparam int BAR_W = ((ACTIVE_COLS / 8) > 0) ? (ACTIVE_COLS / 8) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(TOTAL_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TOTAL_ROWS - 1);

  localparam logic [VIDEO_WIDTH-1:0] PIX_WHITE = {VIDEO_WIDTH{1'b1}};
  localparam logic [VIDEO_WIDTH-1:0] PIX_BLACK = {VIDEO_WIDTH{1'b0}};

  // Stage 1 state
  logic                   r_hsync_q, r_hsync_d;
  logic                   r_vsync_q, r_vsync_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [3:0]             r_pattern_q, r_pattern_d;
  logic [7:0]             frame_cnt_q, frame_cnt_d;
  logic                   fs1_q, fs1_d;

  // Stage 2 (output) state
  logic                   o_hsync_q, o_hsync_d;
  logic                   o_vsync_q, o_vsync_d;
  logic [VIDEO_WIDTH-1:0] o_red_q, o_red_d;
  logic [VIDEO_WIDTH-1:0] o_grn_q, o_grn_d;
  logic [VIDEO_WIDTH-1:0] o_blu_q, o_blu_d;
  logic                   o_frame_start_q, o_frame_start_d;

  // Pixel decode helpers
  logic                   frame_start;
  logic [31:0]            col_ext;
  logic [31:0]            row_ext;
  logic [31:0]            bar_raw;
  logic [2:0]             bar_idx;
  logic                   active;
  logic                   checker_on;
  logic                   border_on;
  logic [VIDEO_WIDTH-1:0] fc_level;

  // A rising VSync edge marks pixel (0,0) of a new frame.
  assign frame_start = vid.i_VSync & ~r_vsync_q;

  assign col_ext    = 32'(col_q);
  assign row_ext    = 32'(row_q);
  assign bar_raw    = col_ext / 32'(BAR_W);
  assign bar_idx    = (bar_raw > 32'd7) ? 3'd7 : bar_raw[2:0];
  assign active     = (col_ext < 32'(ACTIVE_COLS)) && (row_ext < 32'(ACTIVE_ROWS));
  assign checker_on = col_ext[5] ^ row_ext[5];
  assign border_on  = (col_ext == 32'd0) || (col_ext == 32'(ACTIVE_COLS - 1)) ||
                      (row_ext == 32'd0) || (row_ext == 32'(ACTIVE_ROWS - 1));
  // Top bits of the frame counter give a slow brightness ramp.
  assign fc_level   = frame_cnt_q[7 -: VIDEO_WIDTH];

  // Stage 1 next state: sync capture, counters, pattern latch, frame count.
  always_comb begin
    r_hsync_d   = vid.i_HSync;
    r_vsync_d   = vid.i_VSync;
    fs1_d       = frame_start;
    col_d       = col_q;
    row_d       = row_q;
    r_pattern_d = r_pattern_q;
    frame_cnt_d = frame_cnt_q;
    // Frame start wins over wrap so a mid-frame edge resynchronises.
    if (frame_start) begin
      col_d       = '0;
      row_d       = '0;
      r_pattern_d = vid.i_Pattern;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end else if (col_q == COL_LAST) begin
      col_d = '0;
      if (row_q == ROW_LAST) begin
        row_d = '0;
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end else begin
      col_d = col_q + COL_W'(1);
    end
  end

  // Stage 2 next state: pixel colour from stage-1 position and pattern.
  always_comb begin
    o_hsync_d       = r_hsync_q;
    o_vsync_d       = r_vsync_q;
    o_frame_start_d = fs1_q;
    o_red_d         = PIX_BLACK;
    o_grn_d         = PIX_BLACK;
    o_blu_d         = PIX_BLACK;
    if (active) begin
      case (r_pattern_q)
        4'd1: o_red_d = PIX_WHITE;
        4'd2: o_grn_d = PIX_WHITE;
        4'd3: o_blu_d = PIX_WHITE;
        4'd4: begin
          if (checker_on) begin
            o_red_d = PIX_WHITE;
            o_grn_d = PIX_WHITE;
            o_blu_d = PIX_WHITE;
          end else begin
            o_red_d = PIX_BLACK;
          end
        end
        4'd5: begin
          o_red_d = bar_idx[0] ? PIX_WHITE : PIX_BLACK;
          o_grn_d = bar_idx[1] ? PIX_WHITE : PIX_BLACK;
          o_blu_d = bar_idx[2] ? PIX_WHITE : PIX_BLACK;
        end
        4'd6: begin
          if (border_on) begin
            o_red_d = PIX_WHITE;
            o_grn_d = PIX_WHITE;
            o_blu_d = PIX_WHITE;
          end else begin
            o_red_d = PIX_BLACK;
          end
        end
        4'd7: begin
          o_red_d = fc_level;
          o_grn_d = fc_level;
          o_blu_d = fc_level;
        end
        default: begin
          o_red_d = PIX_BLACK;
        end
      endcase
    end else begin
      o_red_d = PIX_BLACK;
    end
  end

  // Pipeline registers with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_hsync_q       <= 1'b0;
      r_vsync_q       <= 1'b0;
      fs1_q           <= 1'b0;
      col_q           <= '0;
      row_q           <= '0;
      r_pattern_q     <= 4'd0;
      frame_cnt_q     <= 8'd0;
      o_hsync_q       <= 1'b0;
      o_vsync_q       <= 1'b0;
      o_frame_start_q <= 1'b0;
      o_red_q         <= PIX_BLACK;
      o_grn_q         <= PIX_BLACK;
      o_blu_q         <= PIX_BLACK;
    end else begin
      r_hsync_q       <= r_hsync_d;
      r_vsync_q       <= r_vsync_d;
      fs1_q           <= fs1_d;
      col_q           <= col_d;
      row_q           <= row_d;
      r_pattern_q     <= r_pattern_d;
      frame_cnt_q     <= frame_cnt_d;
      o_hsync_q       <= o_hsync_d;
      o_vsync_q       <= o_vsync_d;
      o_frame_start_q <= o_frame_start_d;
      o_red_q         <= o_red_d;
      o_grn_q         <= o_grn_d;
      o_blu_q         <= o_blu_d;
    end
  end

  assign vid.o_HSync       = o_hsync_q;
  assign vid.o_VSync       = o_vsync_q;
  assign vid.o_Frame_Start = o_frame_start_q;
  assign vid.o_Red_Video   = o_red_q;
  assign vid.o_Grn_Video   = o_grn_q;
  assign vid.o_Blu_Video   = o_blu_q;

endmodule

// File: tb/tb_vga_test_pattern_gen.sv
// tb_vga_test_pattern_gen
// Drives vga_test_pattern_gen (default parameters) with a behavioural sync
// source, predicts every output pixel two clocks ahead into a scoreboard
// queue, and spot-checks hand-derived pixel values from a vector table plus
// a few multi-cycle sequences (resync, pattern latch, reset, frame counter).
module tb_vga_test_pattern_gen;

  localparam int VW = 3;
  localparam int TC = 800;
  localparam int TR = 525;
  localparam int AC = 640;
  localparam int AR = 480;
  localparam int MX = 7;

  typedef struct {
    logic       hs;
    logic       vs;
    logic       fs;
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
    int         col;
    int         row;
    int         fid;
  } exp_t;

  typedef struct {
    logic [3:0] pat;
    int         col;
    int         row;
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } vec_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  exp_t sb[$];

  // Reference model state (position of the pixel most recently driven)
  int m_col, m_row, m_pat, m_fc, m_fid;
  logic m_prev_vs;

  // Last scoreboard entry popped and the DUT outputs seen with it
  int last_col, last_row, last_fid;
  logic last_fs;
  logic [2:0] last_r, last_g, last_b;

  vga_test_pattern_gen_if #(.VIDEO_WIDTH(VW)) vif ();

  vga_test_pattern_gen #(
    .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
    .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .vid    (vif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model_pix(int col, int row, int pat, int fc,
                                     logic hs, logic vs, logic fs, int fid);
    exp_t e;
    int r, g, b, k, v;
    r = 0; g = 0; b = 0;
    if (col < AC && row < AR) begin
      case (pat)
        1: r = MX;
        2: g = MX;
        3: b = MX;
        4: if (((col / 32) % 2) != ((row / 32) % 2)) begin r = MX; g = MX; b = MX; end
        5: begin
          k = col / (AC / 8);
          if (k > 7) k = 7;
          r = (k % 2) ? MX : 0;
          g = ((k / 2) % 2) ? MX : 0;
          b = ((k / 4) % 2) ? MX : 0;
        end
        6: if (col == 0 || col == AC - 1 || row == 0 || row == AR - 1) begin
          r = MX; g = MX; b = MX;
        end
        7: begin
          v = fc / 32;
          r = v; g = v; b = v;
        end
        default: r = 0;
      endcase
    end
    e.hs = hs; e.vs = vs; e.fs = fs;
    e.r = 3'(r); e.g = 3'(g); e.b = 3'(b);
    e.col = col; e.row = row; e.fid = fid;
    return e;
  endfunction

  task automatic check_pixel(input exp_t e);
    vectors++;
    if (vif.o_HSync !== e.hs || vif.o_VSync !== e.vs || vif.o_Frame_Start !== e.fs ||
        vif.o_Red_Video !== e.r || vif.o_Grn_Video !== e.g || vif.o_Blu_Video !== e.b) begin
      miscompares++;
      $display("FAIL pixel fid=%0d col=%0d row=%0d: got hs=%b vs=%b fs=%b rgb=%0d/%0d/%0d, want hs=%b vs=%b fs=%b rgb=%0d/%0d/%0d",
               e.fid, e.col, e.row, vif.o_HSync, vif.o_VSync, vif.o_Frame_Start,
               vif.o_Red_Video, vif.o_Grn_Video, vif.o_Blu_Video,
               e.hs, e.vs, e.fs, e.r, e.g, e.b);
    end
    last_col = e.col; last_row = e.row; last_fid = e.fid;
    last_fs = vif.o_Frame_Start;
    last_r = vif.o_Red_Video; last_g = vif.o_Grn_Video; last_b = vif.o_Blu_Video;
  endtask

  // One clock: compare the output due now, then drive the next input.
  task automatic step(input logic rst_v, input logic vs, input logic [3:0] pat);
    exp_t e;
    logic fs;
    @(negedge clk);
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      check_pixel(e);
    end
    if (!rst_v) begin
      rst_n = 1'b0;
      vif.i_HSync = 1'b0;
      vif.i_VSync = vs;
      vif.i_Pattern = pat;
      m_col = 0; m_row = 0; m_pat = 0; m_fc = 0; m_prev_vs = 1'b0;
      sb.delete();
      e = model_pix(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, -1);
      e.col = -1;
      sb.push_back(e);
      sb.push_back(e);
    end else begin
      fs = vs && !m_prev_vs;
      if (fs) begin
        m_col = 0; m_row = 0; m_pat = int'(pat); m_fc = (m_fc + 1) % 256; m_fid++;
      end else if (m_col == TC - 1) begin
        m_col = 0;
        m_row = (m_row == TR - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
      m_prev_vs = vs;
      rst_n = 1'b1;
      vif.i_HSync = (m_col < AC);
      vif.i_VSync = vs;
      vif.i_Pattern = pat;
      sb.push_back(model_pix(m_col, m_row, m_pat, m_fc, (m_col < AC), vs, fs, m_fid));
    end
  endtask

  task automatic new_frame(input logic [3:0] pat);
    step(1'b1, 1'b0, pat);
    step(1'b1, 1'b1, pat);
  endtask

  // Step until the scoreboard has just popped pixel (col,row) of the current frame.
  task automatic run_to(input logic [3:0] pat, input int col, input int row);
    int tf;
    if (m_fid == 0 || m_pat != int'(pat) || (m_row * TC + m_col) >= (row * TC + col))
      new_frame(pat);
    tf = m_fid;
    for (int n = 0; n < TC * TR && !(last_fid == tf && last_col == col && last_row == row); n++)
      step(1'b1, 1'b1, pat);
    if (!(last_fid == tf && last_col == col && last_row == row)) begin
      vectors++;
      miscompares++;
      $display("FAIL run_to timeout: reached col=%0d row=%0d, want col=%0d row=%0d", last_col, last_row, col, row);
    end
  endtask

  // Wait (bounded) until the frame-start pixel of the current frame is popped.
  task automatic wait_fs_pixel(input string name);
    for (int n = 0; n < 6 && !(last_fid == m_fid && last_col == 0 && last_row == 0); n++)
      step(1'b1, 1'b1, 4'(m_pat));
    if (!(last_fid == m_fid && last_col == 0 && last_row == 0)) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: frame-start pixel never reached", name);
    end
  endtask

  task automatic check_last(input string name, input logic [2:0] wr, input logic [2:0] wg,
                            input logic [2:0] wb, input logic chk_fs, input logic wfs);
    vectors++;
    if (last_r !== wr || last_g !== wg || last_b !== wb || (chk_fs && last_fs !== wfs)) begin
      miscompares++;
      $display("FAIL %s: got rgb=%0d/%0d/%0d fs=%b, want rgb=%0d/%0d/%0d fs=%b",
               name, last_r, last_g, last_b, last_fs, wr, wg, wb, wfs);
    end
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if (vif.o_HSync !== 1'b0 || vif.o_VSync !== 1'b0 || vif.o_Frame_Start !== 1'b0 ||
        vif.o_Red_Video !== 3'd0 || vif.o_Grn_Video !== 3'd0 || vif.o_Blu_Video !== 3'd0) begin
      miscompares++;
      $display("FAIL %s: got hs=%b vs=%b fs=%b rgb=%0d/%0d/%0d, want all zero", name,
               vif.o_HSync, vif.o_VSync, vif.o_Frame_Start,
               vif.o_Red_Video, vif.o_Grn_Video, vif.o_Blu_Video);
    end
  endtask

  vec_t tbl[30];

  initial begin
    tbl = '{
      '{4'd0,    5,  0, 3'd0, 3'd0, 3'd0},
      '{4'd1,    5,  0, 3'd7, 3'd0, 3'd0},
      '{4'd1,  640,  0, 3'd0, 3'd0, 3'd0},
      '{4'd1,  799,  0, 3'd0, 3'd0, 3'd0},
      '{4'd2,    5,  0, 3'd0, 3'd7, 3'd0},
      '{4'd3,    5,  0, 3'd0, 3'd0, 3'd7},
      '{4'd8,    5,  0, 3'd0, 3'd0, 3'd0},
      '{4'd15,   5,  0, 3'd0, 3'd0, 3'd0},
      '{4'd4,    0,  0, 3'd0, 3'd0, 3'd0},
      '{4'd4,   32,  0, 3'd7, 3'd7, 3'd7},
      '{4'd4,   64,  0, 3'd0, 3'd0, 3'd0},
      '{4'd4,    0, 32, 3'd7, 3'd7, 3'd7},
      '{4'd4,   32, 32, 3'd0, 3'd0, 3'd0},
      '{4'd6,    0,  0, 3'd7, 3'd7, 3'd7},
      '{4'd6,    5,  0, 3'd7, 3'd7, 3'd7},
      '{4'd6,    5,  1, 3'd0, 3'd0, 3'd0},
      '{4'd6,    0,  5, 3'd7, 3'd7, 3'd7},
      '{4'd6,  638,  5, 3'd0, 3'd0, 3'd0},
      '{4'd6,  639,  5, 3'd7, 3'd7, 3'd7},
      '{4'd6,  640,  5, 3'd0, 3'd0, 3'd0},
      '{4'd5,    0, 10, 3'd0, 3'd0, 3'd0},
      '{4'd5,   79, 10, 3'd0, 3'd0, 3'd0},
      '{4'd5,   80, 10, 3'd7, 3'd0, 3'd0},
      '{4'd5,  159, 10, 3'd7, 3'd0, 3'd0},
      '{4'd5,  160, 10, 3'd0, 3'd7, 3'd0},
      '{4'd5,  320, 10, 3'd0, 3'd0, 3'd7},
      '{4'd5,  560, 10, 3'd7, 3'd7, 3'd7},
      '{4'd5,  639, 10, 3'd7, 3'd7, 3'd7},
      '{4'd5,  640, 10, 3'd0, 3'd0, 3'd0},
      '{4'd5,  799, 10, 3'd0, 3'd0, 3'd0}
    };
    vectors = 0; miscompares = 0;
    m_col = 0; m_row = 0; m_pat = 0; m_fc = 0; m_fid = 0; m_prev_vs = 1'b0;
    last_col = -1; last_row = -1; last_fid = -1; last_fs = 1'b0;
    last_r = 3'd0; last_g = 3'd0; last_b = 3'd0;
    rst_n = 1'b0;
    vif.i_HSync = 1'b0; vif.i_VSync = 1'b0; vif.i_Pattern = 4'd0;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0);
    check_all_zero("reset_state");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'd0);

    // Hand-derived pixel values per pattern
    foreach (tbl[i]) begin
      run_to(tbl[i].pat, tbl[i].col, tbl[i].row);
      check_last($sformatf("table[%0d] pat=%0d col=%0d row=%0d", i, tbl[i].pat, tbl[i].col, tbl[i].row),
                 tbl[i].r, tbl[i].g, tbl[i].b, 1'b0, 1'b0);
    end

    // Mid-frame VSync edge resynchronises to pixel (0,0)
    run_to(4'd6, 300, 2);
    check_last("resync_before", 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    new_frame(4'd6);
    wait_fs_pixel("resync");
    check_last("resync_pixel00", 3'd7, 3'd7, 3'd7, 1'b1, 1'b1);

    // Pattern changes only take effect at the next frame start
    run_to(4'd1, 10, 0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 4'd3);
    check_last("pattern_hold_red", 3'd7, 3'd0, 3'd0, 1'b1, 1'b0);
    new_frame(4'd3);
    wait_fs_pixel("pattern_next");
    check_last("pattern_next_blue", 3'd0, 3'd0, 3'd7, 1'b1, 1'b1);

    // Reset mid-active region, then frame start right after release
    run_to(4'd2, 100, 0);
    step(1'b0, 1'b1, 4'd2);
    @(posedge clk);
    #1;
    check_all_zero("reset_first_edge");
    step(1'b0, 1'b1, 4'd2);
    step(1'b0, 1'b1, 4'd2);
    step(1'b1, 1'b1, 4'd2);
    wait_fs_pixel("reset_release");
    check_last("reset_release_fs", 3'd0, 3'd7, 3'd0, 1'b1, 1'b1);

    // Frame counter ramp over 257 short frames
    step(1'b0, 1'b0, 4'd7);
    step(1'b0, 1'b0, 4'd7);
    for (int k = 1; k <= 257; k++) begin
      step(1'b1, 1'b0, 4'd7);
      step(1'b1, 1'b1, 4'd7);
      step(1'b1, 1'b1, 4'd7);
      step(1'b1, 1'b1, 4'd7);
      if (k == 1)   check_last("frame_cnt_1",   3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
      if (k == 32)  check_last("frame_cnt_32",  3'd1, 3'd1, 3'd1, 1'b1, 1'b1);
      if (k == 255) check_last("frame_cnt_255", 3'd7, 3'd7, 3'd7, 1'b1, 1'b1);
      if (k == 256) check_last("frame_cnt_256", 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
